uart_mmio_transceiver: RTL and testbench
========================================

// Module: uart_mmio_transceiver
// PURPOSE
//  CPU-facing UART peripheral at MMIO 0x1000_0000 (data) / 0x1000_0004 (status).
//  Accepts 1-cycle write pulses from the core's TX port and serializes 8N1 frames on uart_txd.
//  Deserializes uart_rxd into a one-byte holding register that the core polls via rx_valid and tx_busy.
//  Pops the byte with rx_re.
// PARAMETERS
//  CLKS_PER_BIT  868  clock cycles per bit period (100 MHz / 115200); must be >= 8; sim uses 16
//  SYNC_STAGES   2    flip-flops in the uart_rxd metastability synchronizer
// PORTS
//  clk          in   1  system clock; single clock domain
//  rst          in   1  synchronous, active-high reset
//  tx_data      in   8  byte to transmit, sampled when tx_we=1
//  tx_we        in   1  1-cycle write strobe from core (sw to 0x1000_0000)
//  tx_busy      out  1  1 while a frame is being shifted out
//  rx_data      out  8  last received byte (holding register)
//  rx_valid     out  1  holding register contains an unread byte
//  rx_re        in   1  1-cycle pop strobe; clears rx_valid
//  rx_overrun   out  1  sticky: a byte was dropped because rx_valid was still set
//  rx_frame_err out  1  1-cycle pulse: stop bit sampled as 0
//  uart_txd     out  1  serial line out, idle high
//  uart_rxd     in   1  serial line in, asynchronous
// BEHAVIOUR
//  Reset: uart_txd=1, tx_busy=0, rx_data=0, rx_valid=0, rx_overrun=0, rx_frame_err=0.
//   Both FSMs go to IDLE and the baud counters clear.
//   rst asserted mid-frame aborts it; uart_txd=1 from the next cycle.
//  TX FSM IDLE->START->DATA(x8, LSB first)->STOP->IDLE; every state lasts CLKS_PER_BIT cycles.
//   tx_we=1 in IDLE at edge N: latch tx_data; tx_busy=1 and uart_txd=0 from edge N (registered).
//   tx_busy returns to 0 at edge N+10*CLKS_PER_BIT, the end of the stop bit.
//   Back-to-back tx_we in the same cycle busy falls starts the next frame with no idle gap.
//   tx_we while tx_busy=1: ignored, byte dropped; the frame in flight is unaffected.
//  RX FSM IDLE->START->DATA(x8)->STOP->IDLE, operating on the synchronized line.
//   IDLE: a falling edge of the synced line loads the counter with CLKS_PER_BIT/2-1 (integer divide).
//   START mid-sample: line=1 means a false start, return to IDLE with no flags.
//    Otherwise count full bit periods and sample each data bit at its midpoint.
//   STOP mid-sample, line=1: rx_data<=shift reg; rx_valid<=1.
//    If rx_valid was already 1 and rx_re=0 that cycle: keep the old rx_data, set rx_overrun, drop the new byte.
//   STOP mid-sample, line=0: rx_frame_err=1 for one cycle, byte discarded; wait in IDLE for line=1.
//   Return to IDLE right after the stop mid-sample, so frames with a short stop bit are caught.
//  rx_re=1: rx_valid<=0 and rx_overrun<=0 next cycle.
//   rx_re with rx_valid=0 has no effect.
//   rx_re coinciding with a new-byte load: new byte loaded, rx_valid stays 1, no overrun.
//  rx_data holds its value after a pop; it changes only on a load.
//  Counter width is $clog2(CLKS_PER_BIT); counters count down to 0 and reload, with no wrap beyond reload.
//  TX and RX are fully independent; simultaneous activity is legal.
// STRUCTURE
//  defines.v gets:
//   `UART_DATA_ADDR 32'h1000_0000, `UART_STAT_ADDR 32'h1000_0004
//   UART state encodings UART_IDLE/START/DATA/STOP (2 bits, shared by TX and RX)
//  Sub-module uart_tx_serializer: TX FSM, baud counter, shift reg.
//  RX path, synchronizer and holding register stay inline in this module.
// TESTING (CLKS_PER_BIT=16)
//  rst held 3 cycles -> uart_txd=1, tx_busy=0, rx_valid=0, rx_overrun=0.
//  tx_we pulse, tx_data=0x55 -> uart_txd = 0,1,0,1,0,1,0,1,0,1, each 16 cycles; tx_busy=0 exactly 160 cycles after the strobe.
//  tx_we 0xAA at cycle 40 of the 0x55 frame -> ignored; line still shows 0x55; no second frame follows.
//  drive an rxd frame for 0xA5 -> rx_valid=1 and rx_data=0xA5 within 3 cycles of the stop midpoint.
//   Then rx_re pulse -> rx_valid=0 next cycle and rx_data stays 0xA5.
//  frames 0x11 then 0x22 with no rx_re -> rx_data=0x11, rx_overrun=1.
//   Then rx_re -> both flags clear.
//  error cases:
//   rxd low for 4 cycles -> no rx_valid.
//   frame with stop bit 0 -> rx_frame_err one pulse, rx_valid stays 0.
//   rst at bit 4 of a TX frame -> uart_txd=1 and tx_busy=0 the next cycle.

Source files
------------

// File: rtl/uart_mmio_transceiver_pkg.sv
// rtl/uart_mmio_transceiver_pkg.sv - shared constants and state encoding for the MMIO UART
// Purpose: MMIO addresses of the UART registers and the 2-bit state encoding
//          used by both the TX serializer and the RX deserializer.
// Ports:   none (package)
package uart_mmio_transceiver_pkg;

   localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;
   localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0004;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 frame serializer with its own baud counter
// Purpose: shifts one byte out LSB first framed by a start (0) and stop (1) bit.
// Ports:   clk, rst      - clock, synchronous active-high reset
//          data, we      - byte and 1-cycle write strobe (ignored while busy)
//          busy          - high from the accepting edge to the end of the stop bit
//          txd           - serial line, idle high
module uart_tx_serializer
   import uart_mmio_transceiver_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       we,
   output logic       busy,
   output logic       txd
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

   uart_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [2:0]    idx_q, idx_d;
   logic          txd_q, txd_d;
   logic          busy_q, busy_d;
   logic          start_frame;

   // A write is taken in IDLE or on the last cycle of a stop bit, so a
   // strobe arriving exactly as the frame ends chains with no idle gap.
   assign start_frame = we && ((state_q == UART_IDLE) ||
                               (state_q == UART_STOP && cnt_q == '0));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      txd_d   = txd_q;
      busy_d  = busy_q;
      case (state_q)
         UART_IDLE: begin
            txd_d  = 1'b1;
            busy_d = 1'b0;
         end
         UART_START: begin
            if (cnt_q == '0) begin
               cnt_d   = RELOAD;
               state_d = UART_DATA;
               idx_d   = 3'd0;
               txd_d   = shreg_q[0];
               shreg_d = {1'b0, shreg_q[7:1]};
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         UART_DATA: begin
            if (cnt_q == '0) begin
               cnt_d = RELOAD;
               if (idx_q == 3'd7) begin
                  state_d = UART_STOP;
                  txd_d   = 1'b1;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  txd_d   = shreg_q[0];
                  shreg_d = {1'b0, shreg_q[7:1]};
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         UART_STOP: begin
            if (cnt_q == '0) begin
               state_d = UART_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = UART_IDLE;
      endcase
      if (start_frame) begin
         state_d = UART_START;
         cnt_d   = RELOAD;
         shreg_d = data;
         txd_d   = 1'b0;
         busy_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= UART_IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         idx_q   <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
      end
   end

   assign busy = busy_q;
   assign txd  = txd_q;

endmodule

// File: rtl/uart_mmio_transceiver.sv
// rtl/uart_mmio_transceiver.sv - CPU-facing 8N1 UART with a one-byte RX holding register
// Purpose: TX via uart_tx_serializer; RX synchronizer, deserializer FSM and
//          holding register with overrun/frame-error reporting.
// Ports:   clk, rst                     - clock, synchronous active-high reset
//          tx_data, tx_we, tx_busy      - transmit byte, write strobe, frame in flight
//          rx_data, rx_valid, rx_re     - holding register, unread flag, pop strobe
//          rx_overrun, rx_frame_err     - sticky dropped-byte flag, bad-stop pulse
//          uart_txd, uart_rxd           - serial out (idle high), async serial in
module uart_mmio_transceiver
   import uart_mmio_transceiver_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_we,
   output logic       tx_busy,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_re,
   output logic       rx_overrun,
   output logic       rx_frame_err,
   output logic       uart_txd,
   input  logic       uart_rxd
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF   = CW'(CLKS_PER_BIT / 2 - 1);

   uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk  (clk),
      .rst  (rst),
      .data (tx_data),
      .we   (tx_we),
      .busy (tx_busy),
      .txd  (uart_txd)
   );

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   line;
   logic                   prev_q;

   uart_state_t   rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [7:0]    rx_shreg_q, rx_shreg_d;
   logic [2:0]    rx_idx_q, rx_idx_d;
   logic          stop_ok, stop_bad;
   logic          drop;

   assign line = sync_q[SYNC_STAGES-1];

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_shreg_d = rx_shreg_q;
      rx_idx_d   = rx_idx_q;
      stop_ok    = 1'b0;
      stop_bad   = 1'b0;
      case (rx_state_q)
         UART_IDLE: begin
            // Only a 1->0 transition starts a frame, so after a frame error
            // the line must return high before the next frame is accepted.
            if (prev_q && !line) begin
               rx_cnt_d   = HALF;
               rx_state_d = UART_START;
            end
         end
         UART_START: begin
            if (rx_cnt_q == '0) begin
               if (line) begin
                  rx_state_d = UART_IDLE;
               end else begin
                  rx_cnt_d   = RELOAD;
                  rx_idx_d   = 3'd0;
                  rx_state_d = UART_DATA;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 1'b1;
            end
         end
         UART_DATA: begin
            if (rx_cnt_q == '0) begin
               rx_cnt_d   = RELOAD;
               rx_shreg_d = {line, rx_shreg_q[7:1]};
               if (rx_idx_q == 3'd7) rx_state_d = UART_STOP;
               else                  rx_idx_d   = rx_idx_q + 1'b1;
            end else begin
               rx_cnt_d = rx_cnt_q - 1'b1;
            end
         end
         UART_STOP: begin
            // Leave at the stop midpoint rather than the end of the bit so a
            // following frame with a short stop bit is still caught.
            if (rx_cnt_q == '0) begin
               rx_state_d = UART_IDLE;
               stop_ok    = line;
               stop_bad   = !line;
            end else begin
               rx_cnt_d = rx_cnt_q - 1'b1;
            end
         end
         default: rx_state_d = UART_IDLE;
      endcase
   end

   // A pop in the same cycle as a load frees the register, so no overrun.
   assign drop = stop_ok && rx_valid && !rx_re;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q       <= '1;
         prev_q       <= 1'b1;
         rx_state_q   <= UART_IDLE;
         rx_cnt_q     <= '0;
         rx_shreg_q   <= '0;
         rx_idx_q     <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         sync_q       <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
         prev_q       <= line;
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_shreg_q   <= rx_shreg_d;
         rx_idx_q     <= rx_idx_d;
         rx_frame_err <= stop_bad;
         if (drop)                    rx_overrun <= 1'b1;
         else if (rx_re && rx_valid)  rx_overrun <= 1'b0;
         if (stop_ok && !drop) begin
            rx_data  <= rx_shreg_q;
            rx_valid <= 1'b1;
         end else if (rx_re) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_mmio_transceiver.sv
// tb/tb_uart_mmio_transceiver.sv - scoreboard bench for the MMIO UART
module tb_uart_mmio_transceiver;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_we = 1'b0;
   logic       tx_busy;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_re = 1'b0;
   logic       rx_overrun;
   logic       rx_frame_err;
   logic       uart_txd;
   logic       uart_rxd = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [7:0] tx_exp[$];
   logic [7:0] rx_exp[$];
   int         tx_frames = 0;
   bit         tx_ignore = 1'b0;
   int         ferr_cycles = 0;
   int         rx_loads = 0;

   uart_mmio_transceiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_data      (tx_data),
      .tx_we        (tx_we),
      .tx_busy      (tx_busy),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_re        (rx_re),
      .rx_overrun   (rx_overrun),
      .rx_frame_err (rx_frame_err),
      .uart_txd     (uart_txd),
      .uart_rxd     (uart_rxd)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // TX monitor: samples each bit of a frame at its midpoint.
   logic [7:0] mon_b;
   logic       mon_start, mon_stop;
   logic [7:0] mon_exp;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && uart_txd === 1'b0) begin
            repeat (7) @(negedge clk);
            mon_start = uart_txd;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               mon_b[i] = uart_txd;
            end
            repeat (CPB) @(negedge clk);
            mon_stop = uart_txd;
            if (!tx_ignore) begin
               tx_frames++;
               if (tx_exp.size() == 0) begin
                  check("tx_unexpected_frame", 1, 0);
               end else begin
                  mon_exp = tx_exp.pop_front();
                  check("tx_start_bit", int'(mon_start), 0);
                  check("tx_byte", int'(mon_b), int'(mon_exp));
                  check("tx_stop_bit", int'(mon_stop), 1);
               end
            end
         end
      end
   end

   // RX monitor: each rising rx_valid must present the next expected byte.
   logic       v_prev = 1'b0;
   logic [7:0] rx_e;
   initial begin
      forever begin
         @(negedge clk);
         if (rx_frame_err === 1'b1) ferr_cycles++;
         if (rx_valid === 1'b1 && !v_prev) begin
            rx_loads++;
            if (rx_exp.size() == 0) begin
               check("rx_unexpected_byte", 1, 0);
            end else begin
               rx_e = rx_exp.pop_front();
               check("rx_byte", int'(rx_data), int'(rx_e));
            end
         end
         v_prev = (rx_valid === 1'b1);
      end
   end

   task automatic send_rx(input logic [7:0] b, input logic stopb, output logic v_at);
      uart_rxd = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         tick(CPB);
      end
      uart_rxd = stopb;
      tick(11);
      v_at = rx_valid;
      tick(CPB - 11);
      uart_rxd = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int   n;
      int   loads0;
      logic v;

      rst = 1'b1;
      tick(3);
      check("reset_txd", int'(uart_txd), 1);
      check("reset_tx_busy", int'(tx_busy), 0);
      check("reset_rx_valid", int'(rx_valid), 0);
      check("reset_rx_overrun", int'(rx_overrun), 0);
      check("reset_rx_frame_err", int'(rx_frame_err), 0);
      check("reset_rx_data", int'(rx_data), 0);
      rst = 1'b0;
      tick(2);

      // TX 0x55, with an ignored 0xAA write in the middle of the frame
      tx_data = 8'h55;
      tx_exp.push_back(8'h55);
      tx_we = 1'b1;
      tick(1);
      tx_we = 1'b0;
      check("tx_busy_after_strobe", int'(tx_busy), 1);
      check("tx_txd_after_strobe", int'(uart_txd), 0);
      n = 0;
      while (tx_busy && n < 400) begin
         n++;
         if (n == 40) begin
            tx_data = 8'hAA;
            tx_we   = 1'b1;
         end else begin
            tx_we = 1'b0;
         end
         tick(1);
      end
      tx_we = 1'b0;
      check("tx_busy_duration", n, 160);
      tick(200);
      check("tx_frame_count", tx_frames, 1);
      check("tx_idle_line", int'(uart_txd), 1);
      check("tx_busy_idle", int'(tx_busy), 0);

      // RX 0xA5, then pop
      rx_exp.push_back(8'hA5);
      send_rx(8'hA5, 1'b1, v);
      check("rx_valid_latency", int'(v), 1);
      tick(4);
      rx_re = 1'b1;
      tick(1);
      rx_re = 1'b0;
      check("rx_valid_after_pop", int'(rx_valid), 0);
      check("rx_data_after_pop", int'(rx_data), 8'hA5);
      tick(8);

      // Overrun: 0x11 kept, 0x22 dropped
      rx_exp.push_back(8'h11);
      send_rx(8'h11, 1'b1, v);
      check("rx_valid_first", int'(v), 1);
      tick(4);
      send_rx(8'h22, 1'b1, v);
      tick(4);
      check("ovr_rx_data", int'(rx_data), 8'h11);
      check("ovr_flag", int'(rx_overrun), 1);
      check("ovr_rx_valid", int'(rx_valid), 1);
      rx_re = 1'b1;
      tick(1);
      rx_re = 1'b0;
      check("ovr_pop_valid", int'(rx_valid), 0);
      check("ovr_pop_overrun", int'(rx_overrun), 0);
      tick(8);

      // False start: 4-cycle low glitch
      loads0 = rx_loads;
      uart_rxd = 1'b0;
      tick(4);
      uart_rxd = 1'b1;
      tick(200);
      check("false_start_valid", int'(rx_valid), 0);
      check("false_start_loads", rx_loads, loads0);
      check("false_start_ferr", ferr_cycles, 0);

      // Frame error: stop bit 0
      ferr_cycles = 0;
      send_rx(8'h3C, 1'b0, v);
      tick(40);
      check("frame_err_pulse_cycles", ferr_cycles, 1);
      check("frame_err_rx_valid", int'(rx_valid), 0);

      // Reset in the middle of data bit 4 of a TX frame
      tx_ignore = 1'b1;
      tx_data = 8'h0F;
      tx_we = 1'b1;
      tick(1);
      tx_we = 1'b0;
      tick(CPB + 4 * CPB + 8);
      check("abort_busy_before_rst", int'(tx_busy), 1);
      rst = 1'b1;
      tick(1);
      check("abort_txd", int'(uart_txd), 1);
      check("abort_tx_busy", int'(tx_busy), 0);
      rst = 1'b0;
      tick(200);
      tx_ignore = 1'b0;

      check("tx_queue_empty", tx_exp.size(), 0);
      check("rx_queue_empty", rx_exp.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
